// File: rtl/bias_relu_stage_if.sv
// Stream interface for bias_relu_stage: upstream lane sums in, activated
// lane results out, with valid/ready on both sides plus beat position.
interface bias_relu_stage_if #(
  parameter int N_adder_tree = 16,
  parameter int DW           = 18,
  parameter int NUM_BEATS    = 65
);
  localparam int W  = N_adder_tree * DW;
  localparam int CW = $clog2(NUM_BEATS);

  logic [W-1:0]  acc_in;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [CW-1:0] beat_cnt;

  modport slave (
    input  acc_in, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, beat_cnt
  );

  modport master (
    output acc_in, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, beat_cnt
  );
endinterface

// File: rtl/bias_relu_stage.sv
// Two-stage bias add, saturate and ReLU over N_adder_tree lanes, with a
// per-pass beat counter. Define BIAS_RELU_EN to enable ReLU after saturation.
module bias_relu_stage #(
  parameter int N_adder_tree = 16,
  parameter int DW           = 18,
  parameter int NUM_BEATS    = 65
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_adder_tree*DW-1:0] bias_in,
  bias_relu_stage_if.slave         io
);
  localparam int W  = N_adder_tree * DW;
  localparam int SW = N_adder_tree * (DW + 1);
  localparam int CW = $clog2(NUM_BEATS);
  localparam logic [CW-1:0] LAST = CW'(NUM_BEATS - 1);
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  logic          advance;
  logic          s1_valid;
  logic [SW-1:0] s1_sum;
  logic [SW-1:0] sum_d;
  logic [W-1:0]  act_d;

  assign advance     = !io.out_valid || io.out_ready;
  assign io.in_ready = advance;
  assign io.out_last = io.out_valid && (io.beat_cnt == LAST);

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < N_adder_tree; i++) begin
      sum_d[(DW+1)*i +: DW+1] =
        {io.acc_in[DW*i+DW-1], io.acc_in[DW*i +: DW]} +
        {bias_in[DW*i+DW-1],   bias_in[DW*i +: DW]};
    end
  end

  // Overflow into the guard bit shows up as the top two sum bits disagreeing.
  always_comb begin : sat_relu
    logic [DW:0]   s;
    logic [DW-1:0] lane;
    act_d = '0;
    for (int unsigned i = 0; i < N_adder_tree; i++) begin
      s = s1_sum[(DW+1)*i +: DW+1];
      if (s[DW] != s[DW-1]) begin
        lane = s[DW] ? SMIN : SMAX;
      end else begin
        lane = s[DW-1:0];
      end
`ifdef BIAS_RELU_EN
      if (lane[DW-1]) begin
        lane = '0;
      end
`endif
      act_d[DW*i +: DW] = lane;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_sum       <= '0;
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      io.beat_cnt  <= '0;
    end else begin
      if (advance) begin
        s1_valid     <= io.in_valid;
        io.out_valid <= s1_valid;
        if (io.in_valid) begin
          s1_sum <= sum_d;
        end
        if (s1_valid) begin
          io.out_data <= act_d;
        end
      end
      if (io.out_valid && io.out_ready) begin
        io.beat_cnt <= (io.beat_cnt == LAST) ? '0 : io.beat_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_bias_relu_stage.sv
// Scoreboard bench for bias_relu_stage: driver pushes expected beats, a
// negedge monitor pops and checks data, beat_cnt, out_last and latency.
module tb_bias_relu_stage;
  localparam int N  = 16;
  localparam int DW = 18;
  localparam int NB = 65;
  localparam int W  = N * DW;
  localparam int CW = $clog2(NB);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] bias;

  bias_relu_stage_if #(.N_adder_tree(N), .DW(DW), .NUM_BEATS(NB)) bus ();

  bias_relu_stage #(.N_adder_tree(N), .DW(DW), .NUM_BEATS(NB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bias_in (bias),
    .io      (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  logic [W-1:0] q[$];
  int           iss[$];
  int           exp_cnt = 0;
  int           last_seen = 0;
  bit           lat_chk = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] set_lane(input logic [W-1:0] v, input int i, input logic [DW-1:0] x);
    logic [W-1:0] r;
    r = v;
    r[DW*i +: DW] = x;
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_lane(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 131071) s = 131071;
    else if (s < -131072) s = -131072;
`ifdef BIAS_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[DW-1:0];
  endfunction

  function automatic logic [W-1:0] ref_vec(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[DW*i +: DW] = ref_lane(a[DW*i +: DW], b[DW*i +: DW]);
    return r;
  endfunction

  function automatic logic [W-1:0] mk(input int k);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[DW*i +: DW] = DW'(k * 7919 + i * 12345 + k * k * 31);
    return r;
  endfunction

  // Monitor: one check set per output transfer
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: got %h expected no beat", bus.out_data);
      end else begin
        logic [W-1:0] e;
        int t;
        e = q.pop_front();
        t = iss.pop_front();
        chk("out_data", bus.out_data, e);
        chk("beat_cnt", W'(bus.beat_cnt), W'(exp_cnt));
        chk("out_last", W'(bus.out_last), W'(exp_cnt == NB - 1));
        if (lat_chk) chk("latency", W'(cyc - t), W'(2));
      end
      if (bus.out_last) last_seen++;
      exp_cnt = (exp_cnt == NB - 1) ? 0 : exp_cnt + 1;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] e);
    bit done;
    done = 1'b0;
    bus.acc_in   = a;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        q.push_back(e);
        iss.push_back(cyc);
        done = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL send_timeout: got in_ready=0 expected in_ready=1 within 200 cycles");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge clk);
    #1;
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d beats outstanding expected 0", q.size());
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_beat_cnt", W'(bus.beat_cnt), W'(0));
    chk("rst_out_last", W'(bus.out_last), W'(0));
    q.delete();
    iss.delete();
    exp_cnt = 0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] v1, b1, e1, b2;
  logic [W-1:0] held_d;
  logic [CW-1:0] held_c;
  int last0;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.acc_in = '0;
    bias = '0;
    #2;
    chk("reset_out_valid", W'(bus.out_valid), W'(0));
    chk("reset_out_data", bus.out_data, '0);
    chk("reset_beat_cnt", W'(bus.beat_cnt), W'(0));
    chk("reset_out_last", W'(bus.out_last), W'(0));
    chk("reset_in_ready", W'(bus.in_ready), W'(1));
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed value path, ReLU and saturation lanes
    v1 = '0; b1 = '0; e1 = '0;
    v1 = set_lane(v1, 0, 18'd100);     b1 = set_lane(b1, 0, 18'd2512);
    v1 = set_lane(v1, 1, 18'h00000);   b1 = set_lane(b1, 1, 18'h3F4A4);
    v1 = set_lane(v1, 2, 18'h1FFFF);   b1 = set_lane(b1, 2, 18'h00001);
    v1 = set_lane(v1, 3, 18'h20000);   b1 = set_lane(b1, 3, 18'h3FFFF);
    e1 = set_lane(e1, 0, 18'd2612);
    e1 = set_lane(e1, 2, 18'h1FFFF);
`ifndef BIAS_RELU_EN
    e1 = set_lane(e1, 1, 18'h3F4A4);
    e1 = set_lane(e1, 3, 18'h20000);
`endif
    bias = b1;
    lat_chk = 1'b1;
    send(v1, e1);
    bus.in_valid = 1'b0;
    drain();
    lat_chk = 1'b0;

    // Uniform patterns against a varied bias vector
    b2 = '0;
    for (int i = 0; i < N; i++) b2[DW*i +: DW] = DW'(i * 9000 - 60000);
    bias = b2;
    v1 = {N{18'h1FFFF}}; send(v1, ref_vec(v1, b2));
    v1 = {N{18'h20000}}; send(v1, ref_vec(v1, b2));
    v1 = {(N/2){18'h00123, 18'h3FEDC}}; send(v1, ref_vec(v1, b2));
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: stall the output for four cycles mid-stream
    fork
      begin
        for (int k = 0; k < 4; k++) send(mk(k), ref_vec(mk(k), b2));
        bus.in_valid = 1'b0;
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          if (j == 0) begin
            held_d = bus.out_data;
            held_c = bus.beat_cnt;
          end
          chk("stall_out_valid", W'(bus.out_valid), W'(1));
          chk("stall_in_ready", W'(bus.in_ready), W'(0));
          if (j != 0) begin
            chk("stall_hold_data", bus.out_data, held_d);
            chk("stall_hold_cnt", W'(bus.beat_cnt), W'(held_c));
          end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Counter: two full passes from a fresh start
    pulse_reset();
    last0 = last_seen;
    for (int k = 0; k < 130; k++) send(mk(k + 10), ref_vec(mk(k + 10), b2));
    bus.in_valid = 1'b0;
    drain();
    chk("last_count", W'(last_seen - last0), W'(2));
    chk("cnt_after_passes", W'(bus.beat_cnt), W'(0));

    // Reset with two beats still in the pipeline
    for (int k = 0; k < 3; k++) send(mk(k + 200), ref_vec(mk(k + 200), b2));
    bus.in_valid = 1'b0;
    #1;
    pulse_reset();
    send(mk(300), ref_vec(mk(300), b2));
    bus.in_valid = 1'b0;
    drain();
    repeat (5) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bias_relu_stage.md
Name: bias_relu_stage

Overview:
- Consumes the 16-lane, 18-bit adder-tree partial sums for one output-channel group of a conv layer.
- Adds the per-lane 18-bit constant bias vector driven by the layer's BIAS bank, saturates, applies ReLU, and registers the result.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Counts output beats per layer pass and flags the last beat to the downstream buffer writer.

Parameters:
- N_adder_tree, 16, number of parallel lanes.
- DW, 18, signed two's-complement width of the accumulator, the bias and the output (same fixed-point format).
- NUM_BEATS, 65, output beats per layer pass; sets the out_last position.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- acc_in  input  N_adder_tree*DW  packed lane sums; lane i = acc_in[DW*(i+1)-1:DW*i].
- bias_in  input  N_adder_tree*DW  packed constant biases, same lane packing; static during operation.
- in_valid  input  1  acc_in is valid.
- in_ready  output  1  stage accepts acc_in this cycle.
- out_data  output  N_adder_tree*DW  packed activated results.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  marks beat NUM_BEATS-1 of the pass; qualified by out_valid.
- beat_cnt  output  $clog2(NUM_BEATS)  index of the beat currently presented on out_data.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All pipeline valids, out_valid, out_last and beat_cnt go to 0.
  - out_data goes to 0.
  - Any in-flight data is discarded.
- Pipeline:
  - advance = !out_valid || out_ready.
  - in_ready = advance, combinational; it does not depend on in_valid.
  - A transfer occurs on in_valid && in_ready; on that edge, stage-1 registers load.
  - Both stages update only when advance is 1; otherwise they hold.
  - Bubbles are not compressed during a stall.
- Stage 1:
  - Per lane, sum = sext(acc) + sext(bias) at DW+1 bits.
  - s1_valid <= in_valid when advance.
- Stage 2, per lane:
  - Saturate sum to DW signed: above 2^(DW-1)-1 clamps to 0x1FFFF; below -2^(DW-1) clamps to 0x20000.
  - Then ReLU: negative results become 0.
  - out_valid <= s1_valid when advance.
- Latency: 2 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 beat per cycle.
- Stall:
  - While out_valid=1 and out_ready=0: out_data, out_last and beat_cnt hold stable, and in_ready=0.
  - An input transfer and an output transfer can occur in the same cycle.
- Beat counter:
  - beat_cnt increments on each output transfer (out_valid && out_ready).
  - On the transfer at NUM_BEATS-1 it wraps to 0.
  - out_last = out_valid && (beat_cnt == NUM_BEATS-1).
- No overflow indication is produced; saturation is silent.

Optional Feature:
- Macro: BIAS_RELU_EN.
- When defined: behaviour as above, with ReLU applied after saturation.
- When undefined: ReLU is removed. out_data carries the signed saturated sum, including negative values. Latency, handshake and counter are unchanged.

Test Plan:
- Value path: lane0 acc=100, bias=2512 -> out lane0 = 2612, exactly 2 cycles after transfer, out_ready=1.
- ReLU: acc=0, bias=-2908 (0x3F4A4) -> lane 0 with BIAS_RELU_EN; 0x3F4A4 without it.
- Saturation:
  - acc=0x1FFFF, bias=0x00001 -> 0x1FFFF.
  - acc=0x20000, bias=0x3FFFF -> 0 with ReLU; 0x20000 without.
- Backpressure:
  - Stream 4 beats with out_ready=0 for cycles 3-6: in_ready falls, out_data and beat_cnt hold.
  - All 4 beats are delivered in order with no loss or duplication.
- Counter: stream 130 beats -> out_last asserted on beats 64 and 129 only; beat_cnt reads 0 after each.
- Reset mid-stream:
  - Drop rst_n with 2 beats in flight -> out_valid=0 and beat_cnt=0 immediately, async to clk.
  - After release, the next beat emerges with beat_cnt=0.
